// File: rtl/joybus_multi_host.sv
// joybus_multi_host: round-robin JoyBus polling host sharing one tx/rx engine pair across ports
module joybus_multi_host #(
   parameter int          NUM_PORTS         = 4,
   parameter int          POLL_CYCLES       = 500000,
   parameter int          RX_TIMEOUT_CYCLES = 2500,
   parameter int          MAX_RETRIES       = 2,
   parameter logic [7:0]  ID_BYTE           = 8'h05,
   localparam int         PW                = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    poll_en,
   output logic                    tx_start,
   output logic [7:0]              tx_cmd,
   input  logic                    tx_done,
   input  logic                    rx_done,
   input  logic [7:0]              rx_status,
   input  logic [31:0]             rx_data,
   output logic [PW-1:0]           port_sel,
   output logic [32*NUM_PORTS-1:0] cntlr_data,
   output logic [NUM_PORTS-1:0]    present,
   output logic                    busy,
   output logic                    frame_done
);
   localparam int CW = $clog2(POLL_CYCLES + 1);
   localparam int TW = $clog2(RX_TIMEOUT_CYCLES + 1);
   localparam int FW = ($clog2(MAX_RETRIES + 1) > 0) ? $clog2(MAX_RETRIES + 1) : 1;
   typedef enum logic [2:0] {IDLE, ISSUE, WAIT_TX, WAIT_RX, UPDATE} state_t;
   state_t                        state_q, state_d;
   logic [CW-1:0]                 cnt_q, cnt_d;
   logic [TW-1:0]                 tmr_q, tmr_d;
   logic [PW-1:0]                 port_q, port_d;
   logic [NUM_PORTS-1:0]          present_q, present_d;
   logic [NUM_PORTS-1:0][31:0]    data_q, data_d;
   logic [FW-1:0]                 fail_q [NUM_PORTS];
   logic [FW-1:0]                 fail_d [NUM_PORTS];
   logic                          adv_q, adv_d;
   // state register and per-port bookkeeping
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         tmr_q     <= '0;
         port_q    <= '0;
         present_q <= '0;
         data_q    <= '0;
         fail_q    <= '{default: '0};
         adv_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         tmr_q     <= tmr_d;
         port_q    <= port_d;
         present_q <= present_d;
         data_q    <= data_d;
         fail_q    <= fail_d;
         adv_q     <= adv_d;
      end
   end
   // next state; the response verdict is applied on the resolving edge so data lands one cycle after rx_done
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      tmr_d     = tmr_q;
      port_d    = port_q;
      present_d = present_q;
      data_d    = data_q;
      fail_d    = fail_q;
      adv_d     = adv_q;
      case (state_q)
         IDLE: begin
            cnt_d = poll_en ? cnt_q + CW'(1) : '0;
            if (poll_en && cnt_q == CW'(POLL_CYCLES - 1)) begin
               cnt_d   = '0;
               port_d  = '0;
               state_d = ISSUE;
            end
         end
         ISSUE: state_d = WAIT_TX;
         WAIT_TX: begin
            if (tx_done) begin
               tmr_d   = '0;
               state_d = WAIT_RX;
            end
         end
         WAIT_RX: begin
            tmr_d = tmr_q + TW'(1);
            if (rx_done || tmr_q == TW'(RX_TIMEOUT_CYCLES - 1)) begin
               state_d = UPDATE;
               if (rx_done && rx_status == ID_BYTE) begin
                  fail_d[port_q] = '0;
                  adv_d          = 1'b1;
                  if (present_q[port_q]) data_d[port_q] = rx_data;
                  else present_d[port_q] = 1'b1;
               end else if (fail_q[port_q] < FW'(MAX_RETRIES)) begin
                  fail_d[port_q] = fail_q[port_q] + FW'(1);
                  adv_d          = 1'b0;
               end else begin
                  present_d[port_q] = 1'b0;
                  data_d[port_q]    = '0;
                  fail_d[port_q]    = '0;
                  adv_d             = 1'b1;
               end
            end
         end
         UPDATE: begin
            state_d = (adv_q && port_q == PW'(NUM_PORTS - 1)) ? IDLE : ISSUE;
            port_d  = (adv_q && port_q != PW'(NUM_PORTS - 1)) ? port_q + PW'(1) : port_q;
         end
         default: state_d = IDLE;
      endcase
   end
   assign tx_start   = state_q == ISSUE;
   assign tx_cmd     = tx_start ? {7'b0, present_q[port_q]} : 8'h00;
   assign port_sel   = port_q;
   assign cntlr_data = data_q;
   assign present    = present_q;
   assign busy       = state_q != IDLE;
   assign frame_done = state_q == UPDATE && adv_q && port_q == PW'(NUM_PORTS - 1);
endmodule

// File: tb/tb_joybus_multi_host.sv
// tb_joybus_multi_host: directed scenario bench for the multi-port JoyBus host
module tb_joybus_multi_host;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        poll_en = 1'b0;
   logic        tx_start;
   logic [7:0]  tx_cmd;
   logic        tx_done = 1'b0;
   logic        rx_done = 1'b0;
   logic [7:0]  rx_status = 8'h00;
   logic [31:0] rx_data = 32'h0;
   logic [0:0]  port_sel;
   logic [63:0] cntlr_data;
   logic [1:0]  present;
   logic        busy;
   logic        frame_done;
   int          checks = 0;
   int          failures = 0;
   int          fd_cnt = 0;
   int          ts_cnt = 0;

   joybus_multi_host #(
      .NUM_PORTS(2), .POLL_CYCLES(100), .RX_TIMEOUT_CYCLES(20), .MAX_RETRIES(2), .ID_BYTE(8'h05)
   ) dut (
      .clk(clk), .rst(rst), .poll_en(poll_en), .tx_start(tx_start), .tx_cmd(tx_cmd),
      .tx_done(tx_done), .rx_done(rx_done), .rx_status(rx_status), .rx_data(rx_data),
      .port_sel(port_sel), .cntlr_data(cntlr_data), .present(present), .busy(busy),
      .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (frame_done) fd_cnt++;
      if (tx_start) ts_cnt++;
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      poll_en = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   task automatic wait_start(input int limit, output int n);
      n = -1;
      for (int i = 0; i <= limit; i++) begin
         if (tx_start) begin
            n = i;
            break;
         end
         tick();
      end
      checks++;
      if (n < 0) begin
         failures++;
         $display("FAIL wait_tx_start got=none within %0d cycles exp=tx_start", limit);
      end
   endtask

   task automatic serve(input bit respond, input logic [7:0] st, input logic [31:0] d);
      tick();
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      if (respond) begin
         rx_status = st;
         rx_data = d;
         rx_done = 1'b1;
         tick();
         rx_done = 1'b0;
      end else repeat (20) tick();
   endtask

   task automatic idle_port(input int n);
      int k;
      for (int i = 0; i < n; i++) begin
         wait_start(40, k);
         serve(1'b0, 8'h00, 32'h0);
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({tx_start, tx_cmd, port_sel, busy, frame_done} !== 12'h0 || cntlr_data !== 64'h0 || present !== 2'b00) begin
         failures++;
         $display("FAIL reset_outputs got=%b/%h/%b/%b/%b/%h/%b exp=all zero", tx_start, tx_cmd, port_sel, busy, frame_done, cntlr_data, present);
      end
   endtask

   task automatic test_no_responders();
      int n, fd0;
      do_reset();
      fd0 = fd_cnt;
      poll_en = 1'b1;
      wait_start(200, n);
      checks++;
      if (n != 100) begin
         failures++;
         $display("FAIL first_start_latency got=%0d exp=100", n);
      end
      for (int p = 0; p < 2; p++)
         for (int r = 0; r < 3; r++) begin
            if (p != 0 || r != 0) wait_start(40, n);
            checks++;
            if (tx_cmd !== 8'h00 || port_sel !== p[0:0]) begin
               failures++;
               $display("FAIL probe_cmd p%0d r%0d got=cmd %h port %0d exp=cmd 00 port %0d", p, r, tx_cmd, port_sel, p);
            end
            serve(1'b0, 8'h00, 32'h0);
         end
      tick();
      checks++;
      if (present !== 2'b00 || fd_cnt - fd0 != 1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL frame1_end got=present %b frames %0d busy %b exp=present 00 frames 1 busy 0", present, fd_cnt - fd0, busy);
      end
   endtask

   task automatic test_detect_and_retry();
      int n;
      do_reset();
      poll_en = 1'b1;
      wait_start(200, n);
      serve(1'b1, 8'h05, 32'hFFFF_FFFF);
      checks++;
      if (present !== 2'b01 || cntlr_data !== 64'h0) begin
         failures++;
         $display("FAIL detect_p0 got=present %b data %h exp=present 01 data 0", present, cntlr_data);
      end
      idle_port(3);
      wait_start(300, n);
      checks++;
      if (tx_cmd !== 8'h01 || port_sel !== 1'b0) begin
         failures++;
         $display("FAIL state_cmd got=cmd %h port %0d exp=cmd 01 port 0", tx_cmd, port_sel);
      end
      serve(1'b1, 8'h05, 32'hA000_0000);
      checks++;
      if (cntlr_data !== 64'h0000_0000_A000_0000) begin
         failures++;
         $display("FAIL state_data got=%h exp=%h", cntlr_data, 64'h0000_0000_A000_0000);
      end
      idle_port(3);
      wait_start(300, n);
      for (int r = 0; r < 3; r++) begin
         if (r != 0) wait_start(5, n);
         checks++;
         if (n != (r == 0 ? n : 1) || tx_cmd !== 8'h01 || port_sel !== 1'b0) begin
            failures++;
            $display("FAIL retry r%0d got=gap %0d cmd %h port %0d exp=gap 1 cmd 01 port 0", r, n, tx_cmd, port_sel);
         end
         serve(1'b1, 8'h07, 32'h1234_5678);
         if (r < 2) begin
            checks++;
            if (present !== 2'b01 || cntlr_data[31:0] !== 32'hA000_0000) begin
               failures++;
               $display("FAIL retry_hold r%0d got=present %b data %h exp=present 01 data a0000000", r, present, cntlr_data[31:0]);
            end
         end
      end
      checks++;
      if (present !== 2'b00 || cntlr_data[31:0] !== 32'h0) begin
         failures++;
         $display("FAIL drop_p0 got=present %b data %h exp=present 00 data 0", present, cntlr_data[31:0]);
      end
      wait_start(5, n);
      checks++;
      if (n != 1 || port_sel !== 1'b1 || tx_cmd !== 8'h00) begin
         failures++;
         $display("FAIL advance_p1 got=gap %0d port %0d cmd %h exp=gap 1 port 1 cmd 00", n, port_sel, tx_cmd);
      end
   endtask

   task automatic test_timeout_tie();
      int n;
      do_reset();
      poll_en = 1'b1;
      wait_start(200, n);
      tick();
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      repeat (19) tick();
      rx_status = 8'h05;
      rx_done = 1'b1;
      tick();
      rx_done = 1'b0;
      checks++;
      if (present !== 2'b01) begin
         failures++;
         $display("FAIL tie_verdict got=present %b exp=present 01", present);
      end
      wait_start(5, n);
      checks++;
      if (n != 1 || port_sel !== 1'b1) begin
         failures++;
         $display("FAIL tie_no_retry got=gap %0d port %0d exp=gap 1 port 1", n, port_sel);
      end
   endtask

   task automatic test_reset_mid_rx();
      int n;
      do_reset();
      poll_en = 1'b1;
      wait_start(200, n);
      serve(1'b1, 8'h05, 32'h0);
      wait_start(5, n);
      tick();
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if ({tx_start, tx_cmd, port_sel, busy, frame_done} !== 12'h0 || cntlr_data !== 64'h0 || present !== 2'b00) begin
         failures++;
         $display("FAIL midrx_reset got=%b/%h/%b/%b/%b/%h/%b exp=all zero", tx_start, tx_cmd, port_sel, busy, frame_done, cntlr_data, present);
      end
      rx_status = 8'h05;
      rx_data = 32'hDEAD_BEEF;
      rx_done = 1'b1;
      tick();
      rx_done = 1'b0;
      tick();
      checks++;
      if (cntlr_data !== 64'h0 || present !== 2'b00 || busy !== 1'b0) begin
         failures++;
         $display("FAIL stray_rx got=data %h present %b busy %b exp=data 0 present 00 busy 0", cntlr_data, present, busy);
      end
   endtask

   task automatic test_poll_disable();
      int n, fd0, ts0;
      do_reset();
      poll_en = 1'b1;
      wait_start(200, n);
      fd0 = fd_cnt;
      poll_en = 1'b0;
      serve(1'b1, 8'h05, 32'h0);
      wait_start(5, n);
      checks++;
      if (port_sel !== 1'b1) begin
         failures++;
         $display("FAIL pe_off_p1 got=port %0d exp=port 1", port_sel);
      end
      serve(1'b0, 8'h00, 32'h0);
      idle_port(2);
      tick();
      checks++;
      if (fd_cnt - fd0 != 1) begin
         failures++;
         $display("FAIL pe_off_frame got=frames %0d exp=1", fd_cnt - fd0);
      end
      ts0 = ts_cnt;
      repeat (300) tick();
      checks++;
      if (ts_cnt != ts0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL pe_off_quiet got=starts %0d busy %b exp=starts 0 busy 0", ts_cnt - ts0, busy);
      end
   endtask

   initial begin
      tick();
      test_reset();
      test_no_responders();
      test_detect_and_retry();
      test_timeout_tie();
      test_reset_mid_rx();
      test_poll_disable();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
